// File: rtl/video_pkg.sv
// Shared types and helpers for the 15 kHz -> 31 kHz scandoubler.
package video_pkg;

    localparam int unsigned LB_ENTRY_W = 10;
    localparam int unsigned HCNT_W     = 10;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb333_t;

    typedef struct packed {
        logic    hblank;
        rgb333_t rgb;
    } lb_entry_t;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        P25 = 2'd1,
        P50 = 2'd2,
        P75 = 2'd3
    } scanline_t;

    typedef enum logic [1:0] {
        CAP_WAIT_FIRST,
        CAP_WAIT_SECOND,
        CAP_LIVE
    } capture_t;

    function automatic logic [2:0] dim_component(input logic [2:0] c, input scanline_t mode);
        logic [2:0] res;
        case (mode)
            P25:     res = c - (c >> 2);
            P50:     res = c >> 1;
            P75:     res = c >> 2;
            default: res = c;
        endcase
        return res;
    endfunction

    function automatic rgb333_t dim_rgb(input rgb333_t px, input scanline_t mode);
        rgb333_t res;
        res.r = dim_component(px.r, mode);
        res.g = dim_component(px.g, mode);
        res.b = dim_component(px.b, mode);
        return res;
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Two-bank line store: one write port, one registered read port; the address MSB selects the bank.
module line_buffer_dp
    import video_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W:0]       i_waddr,
    input  logic [LB_ENTRY_W-1:0] i_wdata,
    input  logic [ADDR_W:0]       i_raddr,
    output logic [LB_ENTRY_W-1:0] o_rdata
);

    localparam int unsigned WORDS = 1 << (ADDR_W + 1);

    logic [LB_ENTRY_W-1:0] r_mem [0:WORDS-1];
    logic [LB_ENTRY_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/video_scandoubler.sv
// Line-doubling scan converter: captures one 15 kHz line per bank and replays the
// previous line twice at the 14 MHz output pixel rate, optionally darkening the repeat.
module video_scandoubler
    import video_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_pix_in,
    input  logic       ce_pix_out,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       hblank_in,
    input  logic [2:0] r_in,
    input  logic [2:0] g_in,
    input  logic [2:0] b_in,
    input  logic [1:0] scanlines,
    output logic       hs_out,
    output logic       vs_out,
    output logic       hblank_out,
    output logic [2:0] r_out,
    output logic [2:0] g_out,
    output logic [2:0] b_out,
    output logic       line_odd
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic              r_hs_prev;
    logic [HCNT_W-1:0] r_hcnt_in;
    logic [HCNT_W-1:0] r_line_len;
    logic [HCNT_W-1:0] r_hs_len;
    logic              r_wr_bank;
    logic              r_vs_line;
    logic [HCNT_W-1:0] r_hcnt_out;
    logic              r_line_odd;
    capture_t          r_cap_state;

    logic              r_hs_out;
    logic              r_vs_out;
    logic              r_hblank_out;
    rgb333_t           r_rgb_out;
    logic              r_line_odd_out;

    logic              w_hs_rise;
    logic              w_hs_fall;
    logic [HCNT_W-1:0] w_wr_addr;
    logic              w_wr_en;
    logic              w_wr_bank_sel;
    logic [ADDR_W:0]   w_lb_waddr;
    logic [ADDR_W:0]   w_lb_raddr;
    logic [LB_ENTRY_W-1:0] w_lb_wdata;
    logic [LB_ENTRY_W-1:0] w_lb_rdata;
    lb_entry_t         w_rd_entry;
    logic              w_rd_oob;
    logic              w_blank;
    scanline_t         w_mode;
    rgb333_t           w_rgb;
    capture_t          w_cap_next;
    logic              w_live;

    // hcnt_in holds the address of the pixel most recently written, so at the
    // next HSync edge it equals the last index of the finished line.
    always_comb begin
        w_hs_rise = ce_pix_in &  hs_in & ~r_hs_prev;
        w_hs_fall = ce_pix_in & ~hs_in &  r_hs_prev;
        if (w_hs_rise) begin
            w_wr_addr = '0;
        end else if (r_hcnt_in == '1) begin
            w_wr_addr = r_hcnt_in;
        end else begin
            w_wr_addr = r_hcnt_in + 10'd1;
        end
        w_wr_bank_sel = w_hs_rise ? ~r_wr_bank : r_wr_bank;
        w_wr_en       = ce_pix_in && (32'(w_wr_addr) < DEPTH);
        w_lb_waddr    = {w_wr_bank_sel, w_wr_addr[ADDR_W-1:0]};
        w_lb_wdata    = {hblank_in, r_in, g_in, b_in};
        w_lb_raddr    = {~r_wr_bank, r_hcnt_out[ADDR_W-1:0]};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_prev  <= 1'b0;
            r_hcnt_in  <= '0;
            r_line_len <= '0;
            r_hs_len   <= '0;
            r_wr_bank  <= 1'b0;
            r_vs_line  <= 1'b0;
        end else if (ce_pix_in) begin
            r_hs_prev <= hs_in;
            r_hcnt_in <= w_wr_addr;
            if (w_hs_rise) begin
                r_line_len <= r_hcnt_in;
                r_wr_bank  <= ~r_wr_bank;
                r_vs_line  <= vs_in;
            end
            if (w_hs_fall) begin
                r_hs_len <= w_wr_addr;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt_out <= '0;
            r_line_odd <= 1'b0;
        end else if (w_hs_rise) begin
            r_hcnt_out <= '0;
            r_line_odd <= 1'b0;
        end else if (ce_pix_out) begin
            if (r_hcnt_out == r_line_len) begin
                r_hcnt_out <= '0;
                r_line_odd <= 1'b1;
            end else begin
                r_hcnt_out <= r_hcnt_out + 10'd1;
            end
        end
    end

    line_buffer_dp #(
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .i_clk   (clk_sys),
        .i_we    (w_wr_en),
        .i_waddr (w_lb_waddr),
        .i_wdata (w_lb_wdata),
        .i_raddr (w_lb_raddr),
        .o_rdata (w_lb_rdata)
    );

    // Output stays blanked until a full line sits in the read bank.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_state <= CAP_WAIT_FIRST;
        end else begin
            r_cap_state <= w_cap_next;
        end
    end

    always_comb begin
        w_cap_next = r_cap_state;
        if (w_hs_rise) begin
            case (r_cap_state)
                CAP_WAIT_FIRST:  w_cap_next = CAP_WAIT_SECOND;
                CAP_WAIT_SECOND: w_cap_next = CAP_LIVE;
                default:         w_cap_next = CAP_LIVE;
            endcase
        end
    end

    always_comb begin
        w_live = (r_cap_state == CAP_LIVE);
    end

    // Read data reflects hcnt_out from the previous clock; ce_pix_out is never
    // asserted on consecutive clocks, so it matches the current hcnt_out.
    always_comb begin
        w_rd_entry = lb_entry_t'(w_lb_rdata);
        w_rd_oob   = (32'(r_hcnt_out) >= DEPTH);
        w_blank    = !w_live || w_rd_oob || w_rd_entry.hblank;
        w_mode     = r_line_odd ? scanline_t'(scanlines) : OFF;
        w_rgb      = w_blank ? '0 : dim_rgb(w_rd_entry.rgb, w_mode);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_out       <= 1'b0;
            r_vs_out       <= 1'b0;
            r_hblank_out   <= 1'b1;
            r_rgb_out      <= '0;
            r_line_odd_out <= 1'b0;
        end else if (ce_pix_out) begin
            r_hs_out       <= (r_hcnt_out < r_hs_len);
            r_vs_out       <= r_vs_line;
            r_hblank_out   <= w_blank;
            r_rgb_out      <= w_rgb;
            r_line_odd_out <= r_line_odd;
        end
    end

    assign hs_out     = r_hs_out;
    assign vs_out     = r_vs_out;
    assign hblank_out = r_hblank_out;
    assign r_out      = r_rgb_out.r;
    assign g_out      = r_rgb_out.g;
    assign b_out      = r_rgb_out.b;
    assign line_odd   = r_line_odd_out;

endmodule

// File: tb/tb_video_scandoubler.sv
// Scoreboard bench for video_scandoubler: each driven input line queues the expected
// doubled replay of the line before it; a monitor compares on every output pixel.
module tb_video_scandoubler;

    localparam int ADDR_W = 9;
    localparam int HS_W   = 32;
    localparam int HB_W   = 48;

    logic       clk_sys    = 1'b0;
    logic       reset_n    = 1'b0;
    logic       ce_pix_in  = 1'b0;
    logic       ce_pix_out = 1'b0;
    logic       hs_in      = 1'b0;
    logic       vs_in      = 1'b0;
    logic       hblank_in  = 1'b1;
    logic [2:0] r_in       = '0;
    logic [2:0] g_in       = '0;
    logic [2:0] b_in       = '0;
    logic [1:0] scanlines  = '0;
    logic       hs_out, vs_out, hblank_out, line_odd;
    logic [2:0] r_out, g_out, b_out;

    video_scandoubler #(.ADDR_W(ADDR_W)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_pix_in  (ce_pix_in),
        .ce_pix_out (ce_pix_out),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hblank_in  (hblank_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .scanlines  (scanlines),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .hblank_out (hblank_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .line_odd   (line_odd)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       hblank;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       hs;
        logic       vs;
        logic       odd;
        logic       chk_sync;
    } exp_t;

    exp_t       sb[$];
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         n_obs      = 0;
    bit         armed      = 1'b0;
    bit         arm_edge   = 1'b0;
    int         period_idx = 0;
    int         prev_len   = 1;
    logic       prev_vs    = 1'b0;
    logic [9:0] prev_pix [0:1023];

    function automatic logic [9:0] pix_val(input int kind, input int i);
        logic [2:0] r, g, b;
        logic       hb;
        hb = (i < HB_W);
        if (kind == 1) begin
            r = 3'd7; g = 3'd7; b = 3'd7;
        end else begin
            r = 3'(i); g = 3'(~i); b = 3'(i / 7);
        end
        return {hb, r, g, b};
    endfunction

    function automatic logic [2:0] dim_ref(input logic [2:0] c, input logic [1:0] mode);
        int v;
        v = int'(c);
        case (mode)
            2'd1:    v = v - v / 4;
            2'd2:    v = v / 2;
            2'd3:    v = v / 4;
            default: v = v;
        endcase
        return 3'(v);
    endfunction

    // Expected outputs for one input-line period (2*len output pixels), which
    // replays the previously captured line.
    task automatic push_period(input int len);
        exp_t       e;
        int         h;
        logic [9:0] p;
        for (int s = 0; s < 2 * len; s++) begin
            e = '0;
            if (period_idx == 0) begin
                e.hblank = 1'b1;
            end else begin
                h        = s % prev_len;
                p        = prev_pix[h];
                e.odd    = (s >= prev_len);
                e.hblank = (h >= (1 << ADDR_W)) || p[9];
                if (!e.hblank) begin
                    e.r = e.odd ? dim_ref(p[8:6], scanlines) : p[8:6];
                    e.g = e.odd ? dim_ref(p[5:3], scanlines) : p[5:3];
                    e.b = e.odd ? dim_ref(p[2:0], scanlines) : p[2:0];
                end
                e.hs       = (h < HS_W);
                e.vs       = prev_vs;
                e.chk_sync = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    // One input pixel = 4 clocks: ce_pix_in on phase 0, ce_pix_out on phases 0 and 2.
    task automatic drive_pixel(input logic hs, input logic [9:0] p, input logic vs_set,
                               input logic vs_val, input bit arm);
        @(negedge clk_sys);
        ce_pix_in  = 1'b1;
        ce_pix_out = 1'b1;
        hs_in      = hs;
        hblank_in  = p[9];
        {r_in, g_in, b_in} = p[8:0];
        if (vs_set) vs_in = vs_val;
        arm_edge   = arm;
        @(negedge clk_sys);
        ce_pix_in  = 1'b0;
        ce_pix_out = 1'b0;
        arm_edge   = 1'b0;
        @(negedge clk_sys);
        ce_pix_out = 1'b1;
        @(negedge clk_sys);
        ce_pix_out = 1'b0;
    endtask

    // vs_val is applied from pixel 1 on, so the edge pixel still carries the previous line's vsync.
    task automatic drive_line(input int len, input int kind, input logic vs_val, input int n_drive);
        push_period(len);
        for (int i = 0; i < n_drive; i++) begin
            drive_pixel(i < HS_W, pix_val(kind, i), i > 0, vs_val, (i == 0) && (period_idx == 0));
        end
        for (int i = 0; i < len; i++) prev_pix[i] = pix_val(kind, i);
        prev_len   = len;
        prev_vs    = vs_val;
        period_idx = period_idx + 1;
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_pixel(1'b0, 10'h200, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] sl);
        reset_n    = 1'b0;
        sb.delete();
        armed      = 1'b0;
        period_idx = 0;
        scanlines  = sl;
        hs_in      = 1'b0;
        vs_in      = 1'b0;
        repeat (4) @(negedge clk_sys);
        reset_n = 1'b1;
        drive_idle(4);
    endtask

    task automatic check_drained(input string name);
        drive_idle(4);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL %s_drain: %0d expected pixels left, required 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (hblank_out !== 1'b1) $display("FAIL %s_hblank: got %b, required 1", name, hblank_out);
        else n_pass++;
        n_checks++;
        if ({hs_out, vs_out} !== 2'b00) $display("FAIL %s_sync: got hs=%b vs=%b, required 0 0", name, hs_out, vs_out);
        else n_pass++;
        n_checks++;
        if ({r_out, g_out, b_out} !== 9'd0) $display("FAIL %s_rgb: got %o, required 000", name, {r_out, g_out, b_out});
        else n_pass++;
        n_checks++;
        if (line_odd !== 1'b0) $display("FAIL %s_line_odd: got %b, required 0", name, line_odd);
        else n_pass++;
    endtask

    always @(posedge clk_sys) begin : monitor
        exp_t e;
        bit   ok;
        if (reset_n && ce_pix_out) begin
            #1;
            if (arm_edge) begin
                armed = 1'b1;
            end else if (!armed) begin
                n_checks++;
                if (hblank_out !== 1'b1 || {r_out, g_out, b_out} !== 9'd0)
                    $display("FAIL pre_capture_blank: hblank_out=%b rgb=%o, required hblank_out=1 rgb=000",
                             hblank_out, {r_out, g_out, b_out});
                else n_pass++;
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                n_obs++;
                ok = ({hblank_out, r_out, g_out, b_out} === {e.hblank, e.r, e.g, e.b}) &&
                     (!e.chk_sync || ({hs_out, vs_out, line_odd} === {e.hs, e.vs, e.odd}));
                n_checks++;
                if (!ok)
                    $display("FAIL pixel #%0d: got hb=%b rgb=%o hs=%b vs=%b odd=%b, required hb=%b rgb=%o hs=%b vs=%b odd=%b (sync checked=%b)",
                             n_obs, hblank_out, {r_out, g_out, b_out}, hs_out, vs_out, line_odd,
                             e.hblank, {e.r, e.g, e.b}, e.hs, e.vs, e.odd, e.chk_sync);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_reset_values("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_ramp_no_scanlines();
        do_reset(2'd0);
        for (int k = 0; k < 3; k++) drive_line(448, 0, 1'b0, 448);
        check_drained("ramp");
    endtask

    task automatic test_scanlines();
        for (int m = 1; m < 4; m++) begin
            do_reset(2'(m));
            drive_line(448, 1, 1'b0, 448);
            drive_line(448, 1, 1'b0, 448);
            check_drained($sformatf("scanlines%0d", m));
        end
    endtask

    task automatic test_456_lines();
        do_reset(2'd0);
        for (int k = 0; k < 3; k++) drive_line(456, 0, 1'b0, 456);
        check_drained("len456");
    endtask

    task automatic test_overlong_line();
        do_reset(2'd2);
        drive_line(448, 0, 1'b0, 448);
        drive_line(600, 0, 1'b0, 600);
        drive_line(448, 0, 1'b0, 448);
        drive_line(448, 0, 1'b0, 448);
        check_drained("overlong");
    endtask

    task automatic test_vsync();
        logic vs_pat [0:7];
        vs_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset(2'd0);
        for (int k = 0; k < 8; k++) drive_line(448, 0, vs_pat[k], 448);
        check_drained("vsync");
    endtask

    task automatic test_reset_midline();
        do_reset(2'd1);
        drive_line(448, 0, 1'b0, 448);
        drive_line(448, 0, 1'b1, 448);
        drive_line(448, 0, 1'b1, 200);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("midline_reset");
        do_reset(2'd1);
        for (int k = 0; k < 3; k++) drive_line(448, 0, 1'b0, 448);
        check_drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp_no_scanlines();
        test_scanlines();
        test_456_lines();
        test_overlong_line();
        test_vsync();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
